// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a shift-add multiplier that stalls
// upstream, feeding the EX/MEM pipeline register.
module ex_stage #(
    parameter int WIDTH = 16,
    parameter int SIG_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [3:0]       alu_op,
    input  logic             alu_src,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] immediate,
    input  logic [WIDTH-1:0] pc,
    input  logic [SIG_W-1:0] sig_in,
    output logic             stall_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result_out,
    output logic [WIDTH-1:0] immediate_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [SIG_W-1:0] sig_out,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             carry_flag
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  lat_imm_q, lat_imm_d;
    logic [WIDTH-1:0]  lat_pc_q, lat_pc_d;
    logic [SIG_W-1:0]  lat_sig_q, lat_sig_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  imm_q, imm_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic              z_q, z_d;
    logic              n_q, n_d;
    logic              c_q, c_d;

    logic [WIDTH-1:0]  opb;
    logic [3:0]        sh;
    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_carry;
    logic [WIDTH-1:0]  acc_add;

    assign opb  = alu_src ? immediate : operand_b;
    assign sh   = opb[3:0];
    assign sum  = {1'b0, operand_a} + {1'b0, opb};
    assign diff = {1'b0, operand_a} - {1'b0, opb};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = ~diff[WIDTH];
            end
            OP_AND:   alu_res = operand_a & opb;
            OP_OR:    alu_res = operand_a | opb;
            OP_XOR:   alu_res = operand_a ^ opb;
            OP_SLL:   alu_res = operand_a << sh;
            OP_SRL:   alu_res = operand_a >> sh;
            OP_SRA:   alu_res = $unsigned($signed(operand_a) >>> sh);
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}},
                                 $signed(operand_a) < $signed(opb)};
            OP_PASSB: alu_res = opb;
            default:  alu_res = '0;
        endcase
    end

    assign acc_add = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        lat_imm_d = lat_imm_q;
        lat_pc_d  = lat_pc_q;
        lat_sig_d = lat_sig_q;
        res_d     = res_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        z_d       = z_q;
        n_d       = n_q;
        c_d       = c_q;
        // every edge loads a bubble unless a result is written below
        valid_d   = 1'b0;
        sig_d     = '0;
        stall_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!flush && in_valid) begin
                    if (alu_op == OP_MUL) begin
                        stall_out = 1'b1;
                        mcand_d   = operand_a;
                        mplier_d  = opb;
                        acc_d     = '0;
                        cnt_d     = CW'(WIDTH);
                        lat_imm_d = immediate;
                        lat_pc_d  = pc;
                        lat_sig_d = sig_in;
                        state_d   = S_BUSY;
                    end else begin
                        valid_d = 1'b1;
                        res_d   = alu_res;
                        imm_d   = immediate;
                        pc_d    = pc;
                        sig_d   = sig_in;
                        z_d     = (alu_res == '0);
                        n_d     = alu_res[WIDTH-1];
                        c_d     = alu_carry;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d    = acc_add;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        valid_d = 1'b1;
                        res_d   = acc_add;
                        imm_d   = lat_imm_q;
                        pc_d    = lat_pc_q;
                        sig_d   = lat_sig_q;
                        z_d     = (acc_add == '0);
                        n_d     = acc_add[WIDTH-1];
                        c_d     = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        stall_out = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            lat_imm_q <= '0;
            lat_pc_q  <= '0;
            lat_sig_q <= '0;
            valid_q   <= 1'b0;
            res_q     <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            sig_q     <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            lat_imm_q <= lat_imm_d;
            lat_pc_q  <= lat_pc_d;
            lat_sig_q <= lat_sig_d;
            valid_q   <= valid_d;
            res_q     <= res_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            sig_q     <= sig_d;
            z_q       <= z_d;
            n_q       <= n_d;
            c_q       <= c_d;
        end
    end

    assign out_valid      = valid_q;
    assign alu_result_out = res_q;
    assign immediate_out  = imm_q;
    assign pc_out         = pc_q;
    assign sig_out        = sig_q;
    assign zero_flag      = z_q;
    assign negative_flag  = n_q;
    assign carry_flag     = c_q;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized scoreboard bench for ex_stage: driver pushes expected EX/MEM
// contents, a negedge monitor pops and compares them.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  alu_op = '0;
    logic        alu_src = 1'b0;
    logic [15:0] operand_a = '0;
    logic [15:0] operand_b = '0;
    logic [15:0] immediate = '0;
    logic [15:0] pc = '0;
    logic [6:0]  sig_in = '0;
    logic        stall_out;
    logic        out_valid;
    logic [15:0] alu_result_out;
    logic [15:0] immediate_out;
    logic [15:0] pc_out;
    logic [6:0]  sig_out;
    logic        zero_flag;
    logic        negative_flag;
    logic        carry_flag;

    ex_stage #(.WIDTH(16), .SIG_W(7)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
        .alu_op(alu_op), .alu_src(alu_src), .operand_a(operand_a),
        .operand_b(operand_b), .immediate(immediate), .pc(pc),
        .sig_in(sig_in), .stall_out(stall_out), .out_valid(out_valid),
        .alu_result_out(alu_result_out), .immediate_out(immediate_out),
        .pc_out(pc_out), .sig_out(sig_out), .zero_flag(zero_flag),
        .negative_flag(negative_flag), .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [15:0] imm;
        logic [15:0] pcv;
        logic [6:0]  sig;
        logic        z;
        logic        n;
        logic        c;
        int          ecyc;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    logic [15:0] h_res, h_imm, h_pc;
    logic        h_z, h_n, h_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, req, $time);
        end
    endtask

    // reference model: plain arithmetic on the architectural rules
    function automatic void model(input logic [3:0] op,
                                  input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c);
        longint ua, ub, sa, t;
        int     s;
        ua = a;
        ub = b;
        sa = longint'($signed(a));
        s  = b % 16;
        c  = 1'b0;
        t  = 0;
        case (op)
            0: begin t = ua + ub; c = (t > 65535); end
            1: begin t = ua - ub; c = (ua >= ub); end
            2: t = ua & ub;
            3: t = ua | ub;
            4: t = ua ^ ub;
            5: t = ua << s;
            6: t = ua >> s;
            7: t = sa >>> s;
            8: t = ua * ub;
            9: t = ($signed(a) < $signed(b)) ? 1 : 0;
            10: t = ub;
            default: t = 0;
        endcase
        r = t[15:0];
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out actual=%0h required=none",
                             alu_result_out);
                end else begin
                    m = q.pop_front();
                    chk("cycle", cyc, m.ecyc);
                    chk("result", alu_result_out, m.res);
                    chk("imm_out", immediate_out, m.imm);
                    chk("pc_out", pc_out, m.pcv);
                    chk("sig_out", sig_out, m.sig);
                    chk("zero", zero_flag, m.z);
                    chk("neg", negative_flag, m.n);
                    chk("carry", carry_flag, m.c);
                    h_res = m.res; h_imm = m.imm; h_pc = m.pcv;
                    h_z = m.z; h_n = m.n; h_c = m.c;
                end
            end else begin
                chk("bub_sig", sig_out, 0);
                chk("bub_res", alu_result_out, h_res);
                chk("bub_imm", immediate_out, h_imm);
                chk("bub_pc", pc_out, h_pc);
                chk("bub_flags", {zero_flag, negative_flag, carry_flag},
                    {h_z, h_n, h_c});
            end
        end
    end

    task automatic do_reset();
        #1;
        reset = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        q.delete();
        h_res = '0; h_imm = '0; h_pc = '0;
        h_z = 1'b0; h_n = 1'b0; h_c = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_res", alu_result_out, 0);
        chk("rst_imm", immediate_out, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_sig", sig_out, 0);
        chk("rst_flags", {zero_flag, negative_flag, carry_flag}, 0);
        chk("rst_stall", stall_out, 0);
        reset = 1'b0;
    endtask

    // present one instruction until consumed, squashed, or reset
    task automatic send(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] im,
                        input logic src, input logic [15:0] p,
                        input logic [6:0] sg, input int fl_at,
                        input int rs_at);
        logic [15:0] bb, r;
        logic        c, st;
        int          held;
        exp_t        e;
        bb = src ? im : b;
        model(op, a, bb, r, c);
        alu_op = op; operand_a = a; operand_b = b; immediate = im;
        alu_src = src; pc = p; sig_in = sg;
        in_valid = 1'b1;
        flush = 1'b0;
        held = 0;
        forever begin
            @(negedge clk);
            if (held == rs_at) begin
                do_reset();
                return;
            end
            flush = (held == fl_at);
            #1;
            st = stall_out;
            chk("stall", st, (op == 4'd8 && held < 16 && !flush));
            if (!flush && !st) begin
                e.res = r; e.imm = im; e.pcv = p; e.sig = sg;
                e.z = (r == 0); e.n = r[15]; e.c = c;
                e.ecyc = cyc + 1;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (flush || !st) break;
            held++;
            if (held > 40) begin
                checks++;
                fails++;
                $display("FAIL stall_timeout actual=%0d required=16", held);
                break;
            end
        end
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] op;
        int fl, rs;
        do_reset();
        send(4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0100, 7'h21, -1, -1);
        send(4'd1, 16'h0003, 16'h0000, 16'h0005, 1'b1, 16'h0102, 7'h02, -1, -1);
        send(4'd7, 16'h8000, 16'h0004, 16'h0000, 1'b0, 16'h0104, 7'h03, -1, -1);
        send(4'd9, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0106, 7'h04, -1, -1);
        idle(2);
        send(4'd8, 16'h0123, 16'h0010, 16'h0007, 1'b0, 16'h0200, 7'h11, -1, -1);
        send(4'd0, 16'h0002, 16'h0003, 16'h0009, 1'b0, 16'h0202, 7'h12, -1, -1);
        send(4'd8, 16'h0055, 16'h0033, 16'h0001, 1'b0, 16'h0300, 7'h13, 10, -1);
        send(4'd0, 16'h1000, 16'h0234, 16'h0002, 1'b0, 16'h0302, 7'h14, -1, -1);
        send(4'd8, 16'hFFFF, 16'hFFFF, 16'h0003, 1'b0, 16'h0400, 7'h15, -1, -1);
        send(4'd8, 16'h0100, 16'h0100, 16'h0004, 1'b0, 16'h0402, 7'h16, -1, -1);
        send(4'd8, 16'h1234, 16'h0005, 16'h0005, 1'b0, 16'h0500, 7'h17, -1, 5);
        send(4'd0, 16'h0002, 16'h0003, 16'h0006, 1'b0, 16'h0502, 7'h18, -1, -1);
        send(4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0504, 7'h19, 0, -1);
        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 5) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            fl = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 17)) : -1;
            rs = ($urandom_range(0, 59) == 0) ? int'($urandom_range(0, 6)) : -1;
            send(op, 16'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom), 16'($urandom), 7'($urandom), fl, rs);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        @(negedge clk);
        #1;
        chk("q_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
